text_line_generator: RTL
========================

TEXT_LINE_GENERATOR -- requirements
Module: text_line_generator

Interface
REQ-001 SHALL have parameter N_CHARS, default 8: characters per text line, range 2..64.
REQ-002 SHALL have parameter X0, default 0: left pixel column of the line.
REQ-003 SHALL have parameter Y0, default 0: top pixel row of the line.
REQ-004 SHALL have parameter BLINK_FRAMES, default 30: frames per cursor blink half-period, at least 1.
REQ-005 SHALL have local width IW = clog2(N_CHARS).
REQ-006 SHALL have port clk, input, 1: the single clock, pixel rate.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port video_on, input, 1: the visible-area flag.
REQ-009 SHALL have port pixel_x, input, 10: current pixel column.
REQ-010 SHALL have port pixel_y, input, 10: current pixel row.
REQ-011 SHALL have port wr_en, input, 1: character-buffer write strobe.
REQ-012 SHALL have port wr_idx, input, IW: character slot to write.
REQ-013 SHALL have port wr_char, input, 7: character code to write.
REQ-014 SHALL have port fg_color, input, 3: foreground RGB.
REQ-015 SHALL have port bg_color, input, 3: background RGB.
REQ-016 SHALL have port cursor_en, input, 1: enables the blinking cursor.
REQ-017 SHALL have port cursor_idx, input, IW: cursor slot.
REQ-018 SHALL have port rom_addr, output, 11: font ROM address {char[6:0], row[3:0]}.
REQ-019 SHALL have port rom_data, input, 8: font ROM word; the ROM is synchronous with 1-cycle latency, and bit 7 is the leftmost pixel.
REQ-020 SHALL have port rgb_text, output, 3: registered pixel colour.
REQ-021 SHALL have port text_on, output, 1: registered flag, pixel inside the text region.

Function
REQ-022 SHALL hold N_CHARS x 7-bit character buffer; on clk rising edge with wr_en=1 and wr_idx<N_CHARS, slot wr_idx <= wr_char; wr_idx>=N_CHARS SHALL be ignored.
REQ-023 Text region SHALL be X0 <= pixel_x < X0+8*N_CHARS and Y0 <= pixel_y < Y0+16, compared at 11-bit width without wrap.
REQ-024 Inside region: slot = (pixel_x-X0)>>3, row = (pixel_y-Y0)[3:0], col = (pixel_x-X0)[2:0].
REQ-025 rom_addr SHALL be combinational: {buffer[slot], row} inside region, 11'h000 outside.
REQ-026 Buffer read SHALL return the pre-write value when a write to the same slot occurs in the same cycle; the new value is visible from the next cycle.
REQ-027 Stage 1 SHALL register col, in-region, video_on and cursor-hit (cursor_en & slot==cursor_idx & blink_phase).
REQ-028 Stage 2 SHALL register rgb_text and text_on from stage-1 values and rom_data[7-col].
REQ-029 Latency SHALL be exactly 2 clk cycles from pixel_x/pixel_y/video_on to rgb_text/text_on.
REQ-030 Colour rule: video_on=0 -> 3'b000; outside region -> 3'b000; font bit 1 -> fg_color, font bit 0 -> bg_color; cursor-hit swaps fg_color and bg_color.
REQ-031 text_on SHALL be 1 only when stage-1 in-region=1 and video_on=1.
REQ-032 Frame start SHALL be the first cycle with pixel_x==0 and pixel_y==0 after any cycle where they were not both 0; this requires a 1-bit previous-frame-start register.
REQ-033 Blink counter (clog2(BLINK_FRAMES+1) bits) SHALL increment on each frame start; on reaching BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink_phase.
REQ-034 cursor_en=0 SHALL suppress cursor-hit without stopping the blink counter.
REQ-035 fg_color, bg_color and cursor_idx SHALL be sampled in stage 1 with no extra registering.

Reset
REQ-036 rst_n=0 SHALL asynchronously clear to 0 all buffer slots, the stage-1 and stage-2 registers, rgb_text, text_on, the blink counter, blink_phase and the frame-start history.
REQ-037 After rst_n deasserts, the first valid rgb_text SHALL appear 2 cycles after the first sampled pixel; reset mid-line SHALL force rgb_text=000 immediately.

Verification
REQ-038 Write slots 0..7 with 0x41..0x48, then scan row Y0+3 with N_CHARS=8 -> rom_addr={0x41+slot,4'h3}; rgb_text equals fg/bg per the model ROM bit, delayed exactly 2 cycles.
REQ-039 pixel_x = X0+8*N_CHARS (first pixel right of region) and pixel_y = Y0+16 -> rom_addr=0, rgb_text=000, text_on=0.
REQ-040 Same-cycle write slot 2 = 0x5A while reading slot 2 -> that cycle's rom_addr uses the old code; the next cycle uses 0x5A.
REQ-041 BLINK_FRAMES=2, cursor_en=1, cursor_idx=3 -> slot 3 colours are swapped during frames 2-3, normal in frames 0-1 and 4-5; other slots are never swapped.
REQ-042 video_on=0 inside region with fg=3'b111 -> rgb_text=000, text_on=0 two cycles later.
REQ-043 Assert rst_n=0 mid-scan -> rgb_text=000 and text_on=0 asynchronously; all slots read back 0x00 after release.

Source files
------------

// File: rtl/text_line_generator.sv
// Single-line text overlay: character buffer, font ROM addressing and a
// two-stage pixel pipeline with an optional blinking cursor cell.
module text_line_generator #(
  parameter  int unsigned N_CHARS      = 8,
  parameter  int unsigned X0           = 0,
  parameter  int unsigned Y0           = 0,
  parameter  int unsigned BLINK_FRAMES = 30,
  localparam int unsigned IW           = $clog2(N_CHARS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          video_on,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [6:0]    wr_char,
  input  logic [2:0]    fg_color,
  input  logic [2:0]    bg_color,
  input  logic          cursor_en,
  input  logic [IW-1:0] cursor_idx,
  output logic [10:0]   rom_addr,
  input  logic [7:0]    rom_data,
  output logic [2:0]    rgb_text,
  output logic          text_on
);

  localparam int unsigned BW     = $clog2(BLINK_FRAMES + 1);
  localparam logic [11:0] X_LO   = 12'(X0);
  localparam logic [11:0] Y_LO   = 12'(Y0);
  localparam logic [10:0] X_SPAN = 11'(8 * N_CHARS);
  localparam logic [10:0] Y_SPAN = 11'd16;

  logic [6:0]    r_buf [N_CHARS];
  logic          r_prev_zero;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic [2:0]    r_s1_col;
  logic          r_s1_in;
  logic          r_s1_vid;
  logic          r_s1_hit;
  logic [2:0]    r_s1_fg;
  logic [2:0]    r_s1_bg;

  logic [11:0]   w_dx;
  logic [11:0]   w_dy;
  logic          w_in_region;
  logic [IW-1:0] w_slot;
  logic [3:0]    w_row;
  logic [2:0]    w_col;
  logic [6:0]    w_char;
  logic          w_wr_ok;
  logic          w_frame_start;
  logic          w_hit;
  logic          w_font_bit;
  logic [2:0]    w_rgb;

  // Bit 11 of the difference is the borrow, so the lower bound never wraps.
  assign w_dx        = {2'b00, pixel_x} - X_LO;
  assign w_dy        = {2'b00, pixel_y} - Y_LO;
  assign w_in_region = !w_dx[11] && (w_dx[10:0] < X_SPAN) &&
                       !w_dy[11] && (w_dy[10:0] < Y_SPAN);
  assign w_slot      = w_dx[IW+2:3];
  assign w_row       = w_dy[3:0];
  assign w_col       = w_dx[2:0];
  assign w_char      = w_in_region ? r_buf[w_slot] : 7'h00;
  assign rom_addr    = w_in_region ? {w_char, w_row} : 11'h000;

  assign w_wr_ok       = ({1'b0, wr_idx} < (IW+1)'(N_CHARS));
  assign w_frame_start = (pixel_x == 10'd0) && (pixel_y == 10'd0) && !r_prev_zero;
  assign w_hit         = cursor_en && (w_slot == cursor_idx) && r_blink_phase;

  // Buffer reads are from flops, so a same-cycle write is seen only next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CHARS; i++) r_buf[i] <= 7'h00;
    end else if (wr_en && w_wr_ok) begin
      r_buf[wr_idx] <= wr_char;
    end
  end

  // Frame-start detection and cursor blink timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_zero   <= 1'b0;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_prev_zero <= (pixel_x == 10'd0) && (pixel_y == 10'd0);
      if (w_frame_start) begin
        if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          r_blink_cnt   <= '0;
          r_blink_phase <= !r_blink_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + BW'(1);
        end
      end
    end
  end

  // Stage 1: align pixel attributes with the ROM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_col <= 3'd0;
      r_s1_in  <= 1'b0;
      r_s1_vid <= 1'b0;
      r_s1_hit <= 1'b0;
      r_s1_fg  <= 3'd0;
      r_s1_bg  <= 3'd0;
    end else begin
      r_s1_col <= w_col;
      r_s1_in  <= w_in_region;
      r_s1_vid <= video_on;
      r_s1_hit <= w_hit;
      r_s1_fg  <= fg_color;
      r_s1_bg  <= bg_color;
    end
  end

  assign w_font_bit = rom_data[3'd7 - r_s1_col];

  always_comb begin
    w_rgb = 3'b000;
    if (r_s1_vid && r_s1_in) begin
      w_rgb = (w_font_bit ^ r_s1_hit) ? r_s1_fg : r_s1_bg;
    end
  end

  // Stage 2: registered pixel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_text <= 3'b000;
      text_on  <= 1'b0;
    end else begin
      rgb_text <= w_rgb;
      text_on  <= r_s1_in && r_s1_vid;
    end
  end

endmodule
